// File: rtl/reg4_ctrl_pkg.sv
// rtl/reg4_ctrl_pkg.sv - shared MODO encodings, FSM state codes and direction constants
package reg4_ctrl_pkg;

  localparam logic [1:0] MODO_SHIFT = 2'b00;
  localparam logic [1:0] MODO_ROT   = 2'b01;
  localparam logic [1:0] MODO_LOAD  = 2'b10;
  localparam logic [1:0] MODO_HOLD  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Per-command control bits captured on accept
  typedef struct packed {
    logic dir;
    logic fill;
  } cmdFlagsT;

endpackage

// File: rtl/reg4_ctrl_cnt.sv
// rtl/reg4_ctrl_cnt.sv - loadable down-counter with zero/one flags for the shift sequencer
module reg4_ctrl_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             isZero,
  output logic             isOne
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign isZero = (cnt == '0);
  assign isOne  = (cnt == CNT_W'(1));

endmodule

// File: rtl/reg4_ctrl.sv
// rtl/reg4_ctrl.sv - registro4 sequencer: parallel load then N serial shifts, captures S_OUT
// Optional rotate support via macro REG4_CTRL_ROTATE_EN.
module reg4_ctrl
  import reg4_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic             CMD_DIR,
  input  logic [CNT_W-1:0] CMD_COUNT,
  input  logic             CMD_FILL,
  input  logic             CMD_ROT,
  input  logic             S_OUT,
  output logic             ENB,
  output logic [1:0]       MODO,
  output logic             DIR,
  output logic [WIDTH-1:0] D,
  output logic             S_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RX_DATA
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  logic [1:0]       state;
  logic [1:0]       nextState;
  logic [WIDTH-1:0] dataL;
  cmdFlagsT         flagsL;
  logic             shiftPhase;
  logic             accept;
  logic [CNT_W-1:0] satCount;
  logic             cntZero;
  logic             cntOne;
  logic [1:0]       shiftModo;

  assign accept   = (state == ST_IDLE) && START && !BUSY;
  assign satCount = (CMD_COUNT > MAX_CNT) ? MAX_CNT : CMD_COUNT;

`ifdef REG4_CTRL_ROTATE_EN
  logic rotL;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rotL <= 1'b0;
    end else if (accept) begin
      rotL <= CMD_ROT;
    end
  end

  always_comb begin
    shiftModo = rotL ? MODO_ROT : MODO_SHIFT;
  end
`else
  logic unusedRot;
  assign unusedRot = CMD_ROT;

  always_comb begin
    shiftModo = MODO_SHIFT;
  end
`endif

  reg4_ctrl_cnt #(.CNT_W(CNT_W)) uCnt (
    .clk     (CLK),
    .reset   (RESET),
    .load    (accept),
    .loadVal (satCount),
    .dec     (state == ST_SHIFT),
    .isZero  (cntZero),
    .isOne   (cntOne)
  );

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:  if (accept) nextState = ST_LOAD;
      ST_LOAD:  nextState = cntZero ? ST_FIN : ST_SHIFT;
      ST_SHIFT: if (cntOne) nextState = ST_FIN;
      ST_FIN:   nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so they trail the state by one cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      dataL      <= '0;
      flagsL     <= '0;
      shiftPhase <= 1'b0;
      ENB        <= 1'b0;
      MODO       <= MODO_HOLD;
      DIR        <= DIR_RIGHT;
      D          <= '0;
      S_IN       <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      RX_DATA    <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        dataL       <= CMD_DATA;
        flagsL.dir  <= CMD_DIR;
        flagsL.fill <= CMD_FILL;
      end
      BUSY <= accept | (BUSY & ~DONE);

      // The register shifts on the same edge, so S_OUT still shows the outgoing bit
      if (shiftPhase) begin
        RX_DATA <= {RX_DATA[WIDTH-2:0], S_OUT};
      end

      ENB        <= 1'b0;
      MODO       <= MODO_HOLD;
      S_IN       <= 1'b0;
      DONE       <= 1'b0;
      shiftPhase <= 1'b0;
      case (state)
        ST_LOAD: begin
          ENB     <= 1'b1;
          MODO    <= MODO_LOAD;
          D       <= dataL;
          DIR     <= flagsL.dir;
          RX_DATA <= '0;
        end
        ST_SHIFT: begin
          ENB        <= 1'b1;
          MODO       <= shiftModo;
          DIR        <= flagsL.dir;
          S_IN       <= flagsL.fill;
          shiftPhase <= 1'b1;
        end
        ST_FIN: begin
          DONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
